queue_issue: RTL



---
 rtl/queue_pkg.sv | 8 +
 rtl/queue_issue_select.sv | 44 ++++
 rtl/queue_issue.sv | 56 +++++
 3 files changed

// File: rtl/queue_pkg.sv
// queue_pkg: shared occupancy-width helper and slot index type for queue and queue_issue (supports Size up to MAX_SIZE)
package queue_pkg;
  localparam int MAX_SIZE = 16;
  typedef logic [$clog2(MAX_SIZE)-1:0] slot_idx_t;
  function automatic int size_w(input int size);
    return $clog2(size + 1);
  endfunction
endpackage

// File: rtl/queue_issue_select.sv
// queue_issue_select: combinational prefix-count pairing of candidate slots to free ports (cand, free -> sel_valid, sel_idx, pop; QUEUE_ISSUE_IN_ORDER_EN keeps only the leading run of candidates)
module queue_issue_select
  import queue_pkg::*;
#(
  parameter int Size      = 4,
  parameter int Consumers = 2
) (
  input  logic [Size-1:0]                 cand,
  input  logic [Consumers-1:0]            free,
  output logic [Consumers-1:0]            sel_valid,
  output slot_idx_t [Consumers-1:0]       sel_idx,
  output logic [Size-1:0]                 pop
);
  logic [Size-1:0] c;
  int nf;
  int nc;
  int prank [Consumers];
  always_comb begin
    c = cand;
`ifdef QUEUE_ISSUE_IN_ORDER_EN
    for (int s = 1; s < Size; s++) c[s] = c[s] & c[s-1];
`else
`endif
    nf = 0;
    nc = 0;
    pop = '0;
    sel_valid = '0;
    sel_idx = '0;
    for (int p = 0; p < Consumers; p++) begin
      prank[p] = nf;
      nf = nf + int'(free[p]);
    end
    for (int s = 0; s < Size; s++) begin
      pop[s] = c[s] && (nc < nf);
      for (int p = 0; p < Consumers; p++) begin
        if (c[s] && free[p] && prank[p] == nc) begin
          sel_valid[p] = 1'b1;
          sel_idx[p] = slot_idx_t'(s);
        end
      end
      nc = nc + int'(c[s]);
    end
  end
endmodule

// File: rtl/queue_issue.sv
// queue_issue: oldest-first issue picker popping queue slots (i_size, i_data, i_eligible -> o_pop) onto registered consumer ports (o_valid, o_data, i_accept); QUEUE_ISSUE_IN_ORDER_EN selects program-order issue
module queue_issue
  import queue_pkg::*;
#(
  parameter int  Size      = 4,
  parameter type T         = logic [3:0],
  parameter int  Consumers = 2
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [size_w(Size)-1:0]   i_size,
  input  T [Size-1:0]               i_data,
  input  logic [Size-1:0]           i_eligible,
  output logic [Size-1:0]           o_pop,
  output logic [Consumers-1:0]      o_valid,
  output T [Consumers-1:0]          o_data,
  input  logic [Consumers-1:0]      i_accept
);
  logic [Size-1:0] cand;
  logic [Size-1:0] pop;
  logic [Consumers-1:0] free;
  logic [Consumers-1:0] sel_valid;
  slot_idx_t [Consumers-1:0] sel_idx;
  T [Consumers-1:0] nxt_data;
  assign free = ~o_valid | i_accept;
  assign o_pop = i_rst_n ? pop : '0;
  for (genvar s = 0; s < Size; s++) begin : g_cand
    assign cand[s] = i_eligible[s] && (s < int'(i_size));
  end
  queue_issue_select #(.Size(Size), .Consumers(Consumers)) u_select (
    .cand      (cand),
    .free      (free),
    .sel_valid (sel_valid),
    .sel_idx   (sel_idx),
    .pop       (pop)
  );
  always_comb begin
    nxt_data = o_data;
    for (int p = 0; p < Consumers; p++)
      for (int s = 0; s < Size; s++)
        if (sel_valid[p] && sel_idx[p] == slot_idx_t'(s)) nxt_data[p] = i_data[s];
  end
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_valid <= '0;
      o_data <= '0;
    end else begin
      for (int p = 0; p < Consumers; p++) begin
        if (free[p]) begin
          o_valid[p] <= sel_valid[p];
          o_data[p] <= nxt_data[p];
        end
      end
    end
  end
endmodule
